// File: rtl/pipelined_cla_adder.sv
// Skewed pipelined adder/subtractor: each stage resolves one WIDTH/STAGES slice with
// grouped carry-lookahead logic and hands its carry to the next stage's register.
module pipelined_cla_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4,
    parameter int GROUP  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    input  logic             sub,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             out_valid,
    input  logic             out_ready
);
    localparam int SW = WIDTH / STAGES;
    localparam int NG = SW / GROUP;
    localparam int L  = STAGES - 1;

    if ((WIDTH % STAGES) != 0 || ((WIDTH / STAGES) % GROUP) != 0) begin : g_param_check
        $error("pipelined_cla_adder: WIDTH must split into STAGES slices of whole GROUPs");
    end

    // Handshake: an operand set transfers on a rising edge where in_valid && in_ready;
    // a result transfers where out_valid && out_ready. The whole pipe moves as one
    // (adv), so a stalled output freezes every stage and blocks new operands.
    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv && !rst;

    // Lookahead inside each GROUP-bit group; group carries ripple across the slice.
    function automatic logic [SW:0] cla_slice(input logic [SW-1:0] a,
                                              input logic [SW-1:0] b,
                                              input logic          ci);
        logic [SW-1:0] p;
        logic [SW-1:0] g;
        logic [SW-1:0] s;
        logic          gc;
        logic          c;
        logic          pp;
        int            base;
        p  = a ^ b;
        g  = a & b;
        s  = '0;
        gc = ci;
        for (int grp = 0; grp < NG; grp++) begin
            base = grp * GROUP;
            c    = 1'b0;
            for (int i = 0; i <= GROUP; i++) begin
                c  = 1'b0;
                pp = 1'b1;
                for (int j = i - 1; j >= 0; j--) begin
                    c  = c | (pp & g[base+j]);
                    pp = pp & p[base+j];
                end
                c = c | (pp & gc);
                if (i < GROUP) s[base+i] = p[base+i] ^ c;
            end
            gc = c;
        end
        return {gc, s};
    endfunction

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int IW = WIDTH - k * SW;
        logic [IW-1:0]       a_in;
        logic [IW-1:0]       b_in;
        logic [(k+1)*SW-1:0] s_next;
        logic [(k+1)*SW-1:0] s_q;
        logic                c_in;
        logic                v_in;
        logic                c_q;
        logic                v_q;
        logic [SW:0]         r;

        assign r = cla_slice(a_in[SW-1:0], b_in[SW-1:0], c_in);

        if (k == 0) begin : g_first
            // Subtraction is A + ~B + 1; cin is ignored in that mode.
            assign a_in   = A;
            assign b_in   = sub ? ~B : B;
            assign c_in   = sub | cin;
            assign v_in   = in_valid && in_ready;
            assign s_next = r[SW-1:0];
        end else begin : g_next
            assign a_in   = g_stage[k-1].g_fwd.a_q;
            assign b_in   = g_stage[k-1].g_fwd.b_q;
            assign c_in   = g_stage[k-1].c_q;
            assign v_in   = g_stage[k-1].v_q;
            assign s_next = {r[SW-1:0], g_stage[k-1].s_q};
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (adv) begin
                v_q <= v_in;
                c_q <= r[SW];
                s_q <= s_next;
            end
        end

        if (k < L) begin : g_fwd
            // Only the operand slices not yet added travel onward.
            logic [IW-SW-1:0] a_q;
            logic [IW-SW-1:0] b_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_in[IW-1:SW];
                    b_q <= b_in[IW-1:SW];
                end
            end
        end else begin : g_last
            logic ovf_q;
            logic zero_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (adv) begin
                    ovf_q  <= (a_in[SW-1] == b_in[SW-1]) && (s_next[WIDTH-1] != a_in[SW-1]);
                    zero_q <= (s_next == '0);
                end
            end
        end
    end

    assign sum       = g_stage[L].s_q;
    assign cout      = g_stage[L].c_q;
    assign out_valid = g_stage[L].v_q;
    assign ovf       = g_stage[L].g_last.ovf_q;
    assign zero      = g_stage[L].g_last.zero_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder: directed vectors feed an expected queue, a negedge
// monitor pops and compares each transferred result and checks stall stability.
module tb_pipelined_cla_adder;
    localparam int W  = 32;
    localparam int NV = 14;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] A, B;
    logic         cin, sub, in_valid, in_ready;
    logic [W-1:0] sum;
    logic         cout, ovf, zero, out_valid, out_ready;

    pipelined_cla_adder #(.WIDTH(32), .STAGES(4), .GROUP(4)) dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .cin(cin), .sub(sub),
        .in_valid(in_valid), .in_ready(in_ready), .sum(sum), .cout(cout),
        .ovf(ovf), .zero(zero), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    logic [W-1:0] va [NV];
    logic [W-1:0] vb [NV];
    logic         vcin [NV];
    logic         vsub [NV];
    logic [W+2:0] vexp [NV];   // {sum, cout, ovf, zero}

    logic [W+2:0] exp_q[$];
    int           checks = 0;
    int           errors = 0;
    int           mode   = 0;  // 0: always ready, 1: random, 2: stall ticks 5-7
    int           tick   = 0;

    task automatic set_vec(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic c, input logic s, input logic [W-1:0] es,
                           input logic ec, input logic eo, input logic ez);
        va[i] = a; vb[i] = b; vcin[i] = c; vsub[i] = s;
        vexp[i] = {es, ec, eo, ez};
    endtask

    task automatic check1(input string name, input logic [W+2:0] got, input logic [W+2:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic get_ready(output logic r);
        case (mode)
            0: r = 1'b1;
            1: r = ($urandom_range(0, 3) != 0);
            default: begin
                r = !(tick >= 5 && tick <= 7);
                tick++;
            end
        endcase
    endtask

    // Monitor: a result transfers on the next edge when out_valid && out_ready.
    logic         stalled = 1'b0;
    logic [W+2:0] held;
    always @(negedge clk) begin
        #2;
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled) check1("stall_hold", {out_valid, sum, cout, ovf, zero}, {1'b1, held});
            if (out_valid && !out_ready) begin
                check1("stall_in_ready", {34'd0, in_ready}, 35'd0);
                stalled = 1'b1;
                held    = {sum, cout, ovf, zero};
            end else begin
                stalled = 1'b0;
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_result got=%h", {sum, cout, ovf, zero});
                    end else begin
                        check1("result", {sum, cout, ovf, zero}, exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        logic r;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            get_ready(r);
            out_ready = r;
            in_valid  = 1'b0;
        end
    endtask

    task automatic drive_vec(input int i);
        logic r;
        bit   done;
        int   tries;
        done  = 0;
        tries = 0;
        while (!done) begin
            @(negedge clk);
            get_ready(r);
            out_ready = r;
            A = va[i]; B = vb[i]; cin = vcin[i]; sub = vsub[i];
            in_valid = 1'b1;
            #1;
            if (in_ready) begin
                exp_q.push_back(vexp[i]);
                done = 1;
            end else if (++tries > 50) begin
                checks++; errors++;
                $display("FAIL drive_timeout got=in_ready_low want=accept");
                done = 1;
            end
        end
    endtask

    task automatic measure_latency(input int i);
        int lat;
        bit seen;
        mode = 0;
        drive_vec(i);
        lat  = 0;
        seen = 0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
            #2;
            lat++;
            if (out_valid) seen = 1;
        end
        check1("latency", 35'(lat), 35'd4);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            idle(1);
            t++;
        end
        check1("drain_left", 35'(exp_q.size()), 35'd0);
        idle(3);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        set_vec(0,  32'h00000001, 32'h00000000, 0, 0, 32'h00000001, 0, 0, 0);
        set_vec(1,  32'hFFFFFFFF, 32'h00000000, 1, 0, 32'h00000000, 1, 0, 1);
        set_vec(2,  32'h7FFFFFFF, 32'h00000001, 0, 0, 32'h80000000, 0, 1, 0);
        set_vec(3,  32'h0000000C, 32'h00000004, 0, 1, 32'h00000008, 1, 0, 0);
        set_vec(4,  32'h00000004, 32'h0000000C, 0, 1, 32'hFFFFFFF8, 0, 0, 0);
        set_vec(5,  32'h00000005, 32'h00000005, 1, 1, 32'h00000000, 1, 0, 1);
        set_vec(6,  32'h80000000, 32'h00000001, 0, 1, 32'h7FFFFFFF, 1, 1, 0);
        set_vec(7,  32'h80000000, 32'h80000000, 0, 0, 32'h00000000, 1, 1, 1);
        set_vec(8,  32'h0000FFFF, 32'h00000001, 0, 0, 32'h00010000, 0, 0, 0);
        set_vec(9,  32'h12345678, 32'h11111111, 1, 0, 32'h2345678A, 0, 0, 0);
        set_vec(10, 32'h00000000, 32'h00000001, 0, 1, 32'hFFFFFFFF, 0, 0, 0);
        set_vec(11, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 32'hFFFFFFFE, 1, 0, 0);
        set_vec(12, 32'hA5A5A5A5, 32'h5A5A5A5A, 1, 0, 32'h00000000, 1, 0, 1);
        set_vec(13, 32'h00FF00FF, 32'h00010001, 0, 1, 32'h00FE00FE, 1, 0, 0);

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        check1("in_ready_in_reset", {34'd0, in_ready}, 35'd0);
        @(negedge clk);
        rst = 1'b0;
        #2;
        check1("reset_outputs", {out_valid, sum, cout, ovf, zero}, 35'd0);
        check1("in_ready_after_reset", {34'd0, in_ready}, 35'd1);

        measure_latency(0);
        drain();

        // Back-to-back stream with a three-tick output stall.
        mode = 2;
        tick = 0;
        for (int i = 0; i < NV; i++) drive_vec(i);
        mode = 0;
        drain();

        // Reset with three operations in flight.
        for (int i = 0; i < 3; i++) drive_vec(i + 1);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0;
        #2;
        check1("in_ready_mid_reset", {34'd0, in_ready}, 35'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            idle(1);
            #2;
            check1("no_ghost_result", {34'd0, out_valid}, 35'd0);
        end
        measure_latency(2);
        drain();

        // Random handshake pacing over the directed table.
        mode = 1;
        for (int n = 0; n < 60; n++) begin
            idle($urandom_range(0, 2));
            drive_vec($urandom_range(0, NV - 1));
        end
        mode = 0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
